fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the multicycle control FSM.
- Holds PC and instruction register (IR), issues instruction-memory reads, selects next PC, and classifies the fetched word.
- Drives the control FSM's opcode and error inputs.
- Consumes the FSM's memRead, irWrite and pcUpdate strobes.

---
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_fetch_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IR, one-deep fetch buffer, next-PC select and opcode classification.
// Optional FETCH_PERF_CNT_EN adds the fetch_count and fault_pc outputs.
module fetch_unit #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read,
  input  logic            ir_write,
  input  logic            pc_update,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic            error,
`ifdef FETCH_PERF_CNT_EN
  output logic [63:0]     fetch_count,
  output logic [XLEN-1:0] fault_pc,
`endif
  output logic [1:0]      err_cause
);

  typedef enum logic [1:0] {IDLE, WAIT, HAVE} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  state_t          state, state_n;
  logic            req_q, req_n;
  logic [XLEN-1:0] addr_n;
  logic            buf_vld, buf_set, buf_clr;
  logic [31:0]     buf_data;
  logic            ir_load;
  logic [31:0]     ir_data;
  logic            err_misalign, err_missing, err_illegal, err_any;
  logic [1:0]      cause_n;
  logic [XLEN-1:0] pc_next;

  assign pc_plus4 = pc + XLEN'(4);
  assign opcode   = instr[6:0];
  // A request registered in the same cycle an error latched must never reach memory.
  assign imem_req = req_q & ~error;

  always_comb begin
    case (pc_sel)
      2'd0:    pc_next = pc_plus4;
      2'd1:    pc_next = br_target;
      2'd2:    pc_next = jalr_target & ~XLEN'(1);
      default: pc_next = pc;
    endcase
  end

  always_comb begin
    state_n      = state;
    req_n        = 1'b0;
    addr_n       = imem_addr;
    ir_load      = 1'b0;
    ir_data      = imem_rdata;
    buf_set      = 1'b0;
    buf_clr      = 1'b0;
    err_misalign = 1'b0;
    err_missing  = 1'b0;
    if (!error) begin
      case (state)
        IDLE: begin
          if (mem_read) begin
            if (pc[1:0] != 2'b00) begin
              err_misalign = 1'b1;
            end else begin
              req_n   = 1'b1;
              addr_n  = pc;
              state_n = WAIT;
            end
          end
          if (ir_write) err_missing = 1'b1;
        end
        WAIT: begin
          if (imem_valid) begin
            if (ir_write) begin
              ir_load = 1'b1;
              state_n = IDLE;
            end else begin
              buf_set = 1'b1;
              state_n = HAVE;
            end
          end else if (ir_write) begin
            err_missing = 1'b1;
          end
        end
        HAVE: begin
          if (ir_write) begin
            ir_load = 1'b1;
            ir_data = buf_data;
            buf_clr = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    err_illegal = ir_load & ~is_legal(ir_data[6:0]);
    err_any     = err_misalign | err_missing | err_illegal;
    cause_n     = err_misalign ? 2'd1 : (err_missing ? 2'd3 : 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_q     <= 1'b0;
      imem_addr <= RESET_PC;
      pc        <= RESET_PC;
      instr     <= NOP;
      buf_vld   <= 1'b0;
      error     <= 1'b0;
      err_cause <= 2'd0;
    end else begin
      req_q <= req_n;
      if (!error) begin
        state     <= state_n;
        imem_addr <= addr_n;
        if (pc_update) pc <= pc_next;
        if (ir_load) instr <= ir_data;
        if (buf_set) buf_vld <= 1'b1;
        else if (buf_clr) buf_vld <= 1'b0;
        if (err_any) begin
          error     <= 1'b1;
          err_cause <= cause_n;
        end
      end
    end
  end

  // Buffer payload is only meaningful while buf_vld is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (buf_set) buf_data <= imem_rdata;
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 64'd0;
      fault_pc    <= RESET_PC;
    end else begin
      if (ir_load && !err_any) fetch_count <= fetch_count + 64'd1;
      if (!error && err_any) fault_pc <= pc;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: fetch paths, error causes, PC select and reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, mem_read, ir_write, pc_update, imem_valid;
  logic [1:0]  pc_sel;
  logic [31:0] br_target, jalr_target, imem_rdata;
  logic [31:0] imem_addr, pc, pc_plus4, instr;
  logic        imem_req, error;
  logic [6:0]  opcode;
  logic [1:0]  err_cause;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0] fetch_count;
  logic [31:0] fault_pc;
`endif

  int checks = 0;
  int errors = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .ir_write(ir_write),
    .pc_update(pc_update), .pc_sel(pc_sel), .br_target(br_target),
    .jalr_target(jalr_target), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .pc(pc),
    .pc_plus4(pc_plus4), .instr(instr), .opcode(opcode), .error(error),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count(fetch_count), .fault_pc(fault_pc),
`endif
    .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 0; ir_write = 0; pc_update = 0; imem_valid = 0;
    pc_sel = 2'd0; br_target = 32'h0; jalr_target = 32'h0; imem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; step(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (instr !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h expected %h", instr, 32'h13); end
    checks++; if (opcode !== 7'h13) begin errors++; $display("FAIL reset_opcode: got %h expected %h", opcode, 7'h13); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    checks++; if (error !== 1'b0 || err_cause !== 2'd0) begin errors++; $display("FAIL reset_err: got %b/%0d expected 0/0", error, err_cause); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4: got %h expected 4", pc_plus4); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (fetch_count !== 64'd0 || fault_pc !== 32'h0) begin errors++; $display("FAIL reset_perf: got %0d/%h expected 0/0", fetch_count, fault_pc); end
`endif
  endtask

  task automatic test_normal_fetch();
    do_reset();
    mem_read = 1; step(); mem_read = 0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL normal_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL normal_addr: got %h expected 0", imem_addr); end
    imem_valid = 1; imem_rdata = 32'h0050_0093; ir_write = 1; pc_update = 1; pc_sel = 2'd0;
    #1;
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL normal_pre_pc_plus4: got %h expected 4", pc_plus4); end
    step(); idle_inputs();
    checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL normal_instr: got %h expected 00500093", instr); end
    checks++; if (opcode !== 7'h13) begin errors++; $display("FAIL normal_opcode: got %h expected 13", opcode); end
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL normal_pc: got %h expected 4", pc); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL normal_error: got %b expected 0", error); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL normal_req_oneshot: got %b expected 0", imem_req); end
  endtask

  task automatic test_buffered_and_missing();
    // Continues from test_normal_fetch: pc = 4, FSM idle.
    mem_read = 1; step(); mem_read = 0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL buf_req: got %b/%h expected 1/00000004", imem_req, imem_addr); end
    imem_valid = 1; imem_rdata = 32'h0000_0537; step(); idle_inputs();
    checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL buf_not_yet: got %h expected 00500093", instr); end
    imem_rdata = 32'hDEAD_BEEF; ir_write = 1; step(); idle_inputs();
    checks++; if (instr !== 32'h0000_0537) begin errors++; $display("FAIL buf_instr: got %h expected 00000537", instr); end
    checks++; if (error !== 1'b0 || pc !== 32'h4) begin errors++; $display("FAIL buf_state: got err %b pc %h expected 0/00000004", error, pc); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (fetch_count !== 64'd2) begin errors++; $display("FAIL buf_count: got %0d expected 2", fetch_count); end
`endif
    // Buffer must now be empty, so another IR load is a missing-data fault.
    ir_write = 1; step(); idle_inputs();
    checks++; if (error !== 1'b1 || err_cause !== 2'd3) begin errors++; $display("FAIL missing_err: got %b/%0d expected 1/3", error, err_cause); end
    checks++; if (instr !== 32'h0000_0537) begin errors++; $display("FAIL missing_instr: got %h expected 00000537", instr); end
  endtask

  task automatic test_illegal_opcode();
    do_reset();
    mem_read = 1; step(); mem_read = 0;
    imem_valid = 1; imem_rdata = 32'h0000_007F; ir_write = 1; step(); idle_inputs();
    checks++; if (error !== 1'b1 || err_cause !== 2'd2) begin errors++; $display("FAIL illegal_err: got %b/%0d expected 1/2", error, err_cause); end
    checks++; if (instr !== 32'h7F || opcode !== 7'h7F) begin errors++; $display("FAIL illegal_instr: got %h/%h expected 0000007f/7f", instr, opcode); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (fetch_count !== 64'd0) begin errors++; $display("FAIL illegal_count: got %0d expected 0", fetch_count); end
`endif
    mem_read = 1; pc_update = 1; pc_sel = 2'd0; step(); idle_inputs();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL illegal_req_frozen: got %b expected 0", imem_req); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL illegal_pc_frozen: got %h expected 0", pc); end
    checks++; if (err_cause !== 2'd2) begin errors++; $display("FAIL illegal_sticky: got %0d expected 2", err_cause); end
  endtask

  task automatic test_misaligned();
    do_reset();
    pc_update = 1; pc_sel = 2'd1; br_target = 32'h102; step(); idle_inputs();
    checks++; if (pc !== 32'h102 || pc_plus4 !== 32'h106) begin errors++; $display("FAIL mis_pc: got %h/%h expected 00000102/00000106", pc, pc_plus4); end
    // Misaligned fetch and missing-data fault together: misalignment takes priority.
    mem_read = 1; ir_write = 1; step(); idle_inputs();
    checks++; if (error !== 1'b1 || err_cause !== 2'd1) begin errors++; $display("FAIL mis_err: got %b/%0d expected 1/1", error, err_cause); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b expected 0", imem_req); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (fault_pc !== 32'h102) begin errors++; $display("FAIL mis_fault_pc: got %h expected 00000102", fault_pc); end
`endif
    step();
    checks++; if (imem_req !== 1'b0 || err_cause !== 2'd1) begin errors++; $display("FAIL mis_hold: got %b/%0d expected 0/1", imem_req, err_cause); end
  endtask

  task automatic test_jalr_wrap();
    do_reset();
    pc_update = 1; pc_sel = 2'd2; jalr_target = 32'h11; step(); idle_inputs();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL jalr_pc: got %h expected 00000010", pc); end
    pc_update = 1; pc_sel = 2'd3; br_target = 32'h80; step(); idle_inputs();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL sel3_hold: got %h expected 00000010", pc); end
    pc_update = 1; pc_sel = 2'd1; br_target = 32'hFFFF_FFFC; step(); idle_inputs();
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4: got %h expected 0", pc_plus4); end
    pc_update = 1; pc_sel = 2'd0; step(); idle_inputs();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", pc); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL wrap_error: got %b expected 0", error); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    pc_update = 1; pc_sel = 2'd1; br_target = 32'h40; step(); idle_inputs();
    mem_read = 1; step(); mem_read = 0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL rmr_req: got %b/%h expected 1/00000040", imem_req, imem_addr); end
    rst = 1; step(); rst = 0;
    imem_valid = 1; imem_rdata = 32'h0050_0093; step(); idle_inputs();
    checks++; if (pc !== 32'h0 || error !== 1'b0) begin errors++; $display("FAIL rmr_state: got pc %h err %b expected 0/0", pc, error); end
    checks++; if (instr !== 32'h13 || imem_req !== 1'b0) begin errors++; $display("FAIL rmr_ir: got %h/%b expected 00000013/0", instr, imem_req); end
    // Late imem_valid was discarded, so an IR load now has no data.
    ir_write = 1; step(); idle_inputs();
    checks++; if (err_cause !== 2'd3 || instr !== 32'h13) begin errors++; $display("FAIL rmr_discard: got %0d/%h expected 3/00000013", err_cause, instr); end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_normal_fetch();
    test_buffered_and_missing();
    test_illegal_opcode();
    test_misaligned();
    test_jalr_wrap();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
